bus_initiator: RTL and testbench



---
 rtl/bus_initiator.sv | 199 +++++++++++++++++++
 tb/tb_bus_initiator.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bus_initiator                                                  |
// | Single-beat master for the multiplexed 20-bit address / 8-bit data ALE   |
// | bus. Optional macro BUS_WAIT_STATE_EN adds the READY wait-state input.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bus_initiator #(
  parameter int IDLE_CYCLES = 1,
  parameter int ADDR_BITS   = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [7:0]           req_wdata,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_rdata,
`ifdef BUS_WAIT_STATE_EN
  input  logic                 READY,
`endif
  output logic                 CS,
  output logic                 ALE,
  output logic                 RD,
  output logic                 WR,
  output logic [ADDR_BITS-9:0] A,
  inout  wire  [7:0]           AD
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_HOLD    = 3'd2,
    S_STROBE  = 3'd3,
    S_DATA    = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(IDLE_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_gap;
  logic [3:0]           w_gap_next;
  logic                 r_write;
  logic [7:0]           r_addr_lo;
  logic [7:0]           r_wdata;
  logic                 r_cs;
  logic                 r_ale;
  logic                 r_rd_n;
  logic                 r_wr_n;
  logic [ADDR_BITS-9:0] r_a;
  logic                 r_ad_oe;
  logic [7:0]           r_ad_out;
  logic                 r_rsp_valid;
  logic [7:0]           r_rdata;

  logic                 w_accept;
  logic                 w_ready_in;
  logic                 w_write;
  logic [7:0]           w_addr_lo;
  logic [7:0]           w_wdata;
  logic                 w_cs;
  logic                 w_ale;
  logic                 w_rd_n;
  logic                 w_wr_n;
  logic                 w_ad_oe;
  logic [7:0]           w_ad_out;
  logic                 w_capture;

`ifdef BUS_WAIT_STATE_EN
  assign w_ready_in = READY;
`else
  assign w_ready_in = 1'b1;
`endif

  assign req_ready = (r_state == S_IDLE) && (r_gap == 4'd0);
  assign w_accept  = req_valid && req_ready;

  // Request fields are taken straight from the port on the accept cycle so
  // the registered bus outputs already show the new address in ADDR.
  assign w_write   = w_accept ? req_write      : r_write;
  assign w_addr_lo = w_accept ? req_addr[7:0]  : r_addr_lo;
  assign w_wdata   = w_accept ? req_wdata      : r_wdata;
  assign w_capture = (r_state == S_DATA) && w_ready_in && !r_write;

  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap;
    case (r_state)
      S_IDLE: begin
        if (r_gap != 4'd0) begin
          w_gap_next = r_gap - 4'd1;
        end else if (w_accept) begin
          w_state_next = S_ADDR;
        end
      end
      S_ADDR:   w_state_next = S_HOLD;
      S_HOLD:   w_state_next = S_STROBE;
      S_STROBE: w_state_next = S_DATA;
      S_DATA: begin
        if (w_ready_in) begin
          w_state_next = S_RECOVER;
        end
      end
      S_RECOVER: begin
        w_state_next = S_IDLE;
        w_gap_next   = GAP_LOAD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bus pins are decoded from the next state and registered with it.
  always_comb begin
    w_cs     = (w_state_next != S_IDLE);
    w_ale    = (w_state_next == S_ADDR);
    w_rd_n   = 1'b1;
    w_wr_n   = 1'b1;
    w_ad_oe  = 1'b0;
    w_ad_out = r_ad_out;
    case (w_state_next)
      S_ADDR, S_HOLD: begin
        w_ad_oe  = 1'b1;
        w_ad_out = w_addr_lo;
      end
      S_STROBE: begin
        w_rd_n   = w_write;
        w_wr_n   = !w_write;
        w_ad_oe  = 1'b1;
        w_ad_out = w_addr_lo;
      end
      S_DATA: begin
        w_rd_n   = w_write;
        w_wr_n   = !w_write;
        w_ad_oe  = w_write;
        w_ad_out = w_wdata;
      end
      S_RECOVER: begin
        w_ad_oe  = w_write;
        w_ad_out = w_wdata;
      end
      default: begin
        w_ad_oe  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_gap       <= 4'd0;
      r_write     <= 1'b0;
      r_addr_lo   <= 8'd0;
      r_wdata     <= 8'd0;
      r_cs        <= 1'b0;
      r_ale       <= 1'b0;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_a         <= '0;
      r_ad_oe     <= 1'b0;
      r_ad_out    <= 8'd0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_gap       <= w_gap_next;
      if (w_accept) begin
        r_write   <= req_write;
        r_addr_lo <= req_addr[7:0];
        r_wdata   <= req_wdata;
        r_a       <= req_addr[ADDR_BITS-1:8];
      end
      r_cs        <= w_cs;
      r_ale       <= w_ale;
      r_rd_n      <= w_rd_n;
      r_wr_n      <= w_wr_n;
      r_ad_oe     <= w_ad_oe;
      r_ad_out    <= w_ad_out;
      r_rsp_valid <= (w_state_next == S_RECOVER);
      if (w_capture) begin
        r_rdata   <= AD;
      end
    end
  end

  assign CS        = r_cs;
  assign ALE       = r_ale;
  assign RD        = r_rd_n;
  assign WR        = r_wr_n;
  assign A         = r_a;
  assign AD        = r_ad_oe ? r_ad_out : 8'bz;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_initiator.sv
`default_nettype none
// tb_bus_initiator: directed bench for bus_initiator with a small bus
// responder model; a second instance runs with IDLE_CYCLES=3.
module tb_bus_initiator;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // ---------------- instance with default IDLE_CYCLES ----------------
  logic        req_valid, req_ready, req_write, rsp_valid;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata, rsp_rdata;
  logic        cs, ale, rd, wr;
  logic [11:0] a;
  wire  [7:0]  ad;
`ifdef BUS_WAIT_STATE_EN
  logic        ready_in;
`endif

  bus_initiator u_dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
`ifdef BUS_WAIT_STATE_EN
    .READY     (ready_in),
`endif
    .CS        (cs),
    .ALE       (ale),
    .RD        (rd),
    .WR        (wr),
    .A         (a),
    .AD        (ad)
  );

  // ---------------- instance with IDLE_CYCLES=3 ----------------
  logic        req3_valid, req3_ready, req3_write, rsp3_valid;
  logic [19:0] req3_addr;
  logic [7:0]  req3_wdata, rsp3_rdata;
  logic        cs3, ale3, rd3, wr3;
  logic [11:0] a3;
  wire  [7:0]  ad3;
`ifdef BUS_WAIT_STATE_EN
  logic        ready3_in = 1'b1;
`endif

  bus_initiator #(.IDLE_CYCLES(3)) u_dut3 (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req3_valid),
    .req_ready (req3_ready),
    .req_write (req3_write),
    .req_addr  (req3_addr),
    .req_wdata (req3_wdata),
    .rsp_valid (rsp3_valid),
    .rsp_rdata (rsp3_rdata),
`ifdef BUS_WAIT_STATE_EN
    .READY     (ready3_in),
`endif
    .CS        (cs3),
    .ALE       (ale3),
    .RD        (rd3),
    .WR        (wr3),
    .A         (a3),
    .AD        (ad3)
  );

  // ---------------- responder model ----------------
  logic        rd_prev = 1'b0, wr_prev = 1'b0, rd3_prev = 1'b0;
  logic [19:0] lat_addr = 20'd0;
  logic [19:0] wr_addr_last = 20'd0;
  logic [7:0]  wr_data_last = 8'd0;
  logic        wr_seen = 1'b0;
  logic        probe, ovr_en;
  logic [7:0]  ovr_val;

  function automatic logic [7:0] lookup(input logic [19:0] addr, input logic seen,
                                        input logic [19:0] waddr, input logic [7:0] wdat);
    if (seen && addr == waddr) return wdat;
    if (addr == 20'h12345) return 8'hA5;
    return addr[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clock) begin
    rd_prev  <= ~rd;
    wr_prev  <= ~wr;
    rd3_prev <= ~rd3;
    if (ale) lat_addr <= {a, ad};
    if (~wr && wr_prev) begin
      wr_addr_last <= lat_addr;
      wr_data_last <= ad;
      wr_seen      <= 1'b1;
    end
  end

  // Responder drives AD only from the second RD-low cycle (DATA) onward;
  // probe drives 0 to show the initiator has released the bus.
  wire       resp_drive = ~rd & rd_prev;
  wire [7:0] resp_val   = ovr_en ? ovr_val : lookup(lat_addr, wr_seen, wr_addr_last, wr_data_last);
  assign ad  = probe ? 8'h00 : (resp_drive ? resp_val : 8'bz);
  assign ad3 = (~rd3 & rd3_prev) ? 8'h96 : 8'bz;

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++;
    if ({cs, ale, rd, wr, rsp_valid} !== 5'b00110) begin
      bad++; $display("FAIL reset_ctl got=%b exp=00110", {cs, ale, rd, wr, rsp_valid});
    end
    total++;
    if ({a, rsp_rdata} !== 20'h00000) begin
      bad++; $display("FAIL reset_a_rdata got=%h exp=00000", {a, rsp_rdata});
    end
    total++;
    if ({cs3, ale3, rd3, wr3, rsp3_valid} !== 5'b00110) begin
      bad++; $display("FAIL reset3_ctl got=%b exp=00110", {cs3, ale3, rd3, wr3, rsp3_valid});
    end
    probe = 1'b1; #1;
    total++;
    if (ad !== 8'h00) begin
      bad++; $display("FAIL reset_ad_release got=%h exp=00", ad);
    end
    probe = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    total++;
    if ({req_ready, req3_ready} !== 2'b11) begin
      bad++; $display("FAIL reset_ready got=%b exp=11", {req_ready, req3_ready});
    end
  endtask

  // One complete bus cycle on u_dut, checking every phase.
  task automatic bus_txn(input logic wr_op, input logic [19:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rd, input string tag);
    logic [5:0] exp_ctl [6];
    logic [5:0] strobe_ctl;
    strobe_ctl = wr_op ? 6'b101000 : 6'b100100;
    exp_ctl = '{6'b111100, 6'b101100, strobe_ctl, strobe_ctl, 6'b101110, 6'b001101};
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL %s_ready_start got=%b exp=1", tag, req_ready);
    end
    req_valid = 1'b1; req_write = wr_op; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      req_valid = 1'b0;
      req_addr  = 20'h0F0F0;
      req_wdata = 8'hEE;
      total++;
      if ({cs, ale, rd, wr, rsp_valid, req_ready} !== exp_ctl[i]) begin
        bad++;
        $display("FAIL %s_ctl[%0d] got=%b exp=%b", tag, i, {cs, ale, rd, wr, rsp_valid, req_ready}, exp_ctl[i]);
      end
      if (i < 3) begin
        total++;
        if ({a, ad} !== addr) begin
          bad++; $display("FAIL %s_addr_phase[%0d] got=%h exp=%h", tag, i, {a, ad}, addr);
        end
      end
      if (wr_op && (i == 3 || i == 4)) begin
        total++;
        if (ad !== wdata) begin
          bad++; $display("FAIL %s_wdata[%0d] got=%h exp=%h", tag, i, ad, wdata);
        end
      end
      if (!wr_op && i == 3) begin
        total++;
        if (ad !== exp_rd) begin
          bad++; $display("FAIL %s_data_bus got=%h exp=%h", tag, ad, exp_rd);
        end
      end
      if (!wr_op && i == 4) begin
        total++;
        if (rsp_rdata !== exp_rd) begin
          bad++; $display("FAIL %s_rdata got=%h exp=%h", tag, rsp_rdata, exp_rd);
        end
      end
      if ((!wr_op && i == 4) || i == 5) begin
        probe = 1'b1; #1;
        total++;
        if (ad !== 8'h00) begin
          bad++; $display("FAIL %s_ad_release[%0d] got=%h exp=00", tag, i, ad);
        end
        probe = 1'b0;
      end
      if (i == 5) begin
        total++;
        if (a !== addr[19:8]) begin
          bad++; $display("FAIL %s_a_hold got=%h exp=%h", tag, a, addr[19:8]);
        end
      end
    end
  endtask

  task automatic test_read();
    bus_txn(1'b0, 20'h12345, 8'h00, 8'hA5, "read");
  endtask

  task automatic test_write_readback();
    bus_txn(1'b1, 20'hFFFFF, 8'h3C, 8'h00, "write");
    bus_txn(1'b0, 20'hFFFFF, 8'h00, 8'h3C, "readback");
  endtask

  task automatic test_back_to_back();
    int         ale_idx [3];
    int         n_ale   = 0;
    int         accepts = 0;
    logic       ale_q   = 1'b0;
    logic [29:0] rdy_vec = '0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00100;
    for (int i = 0; i < 30; i++) begin
      if (ale && !ale_q && n_ale < 3) begin
        ale_idx[n_ale] = i;
        n_ale++;
      end
      ale_q = ale;
      rdy_vec[i] = req_ready;
      if (req_valid && req_ready) accepts++;
      @(negedge clock);
      if (accepts == 3) req_valid = 1'b0;
    end
    total++;
    if (n_ale !== 3) begin
      bad++; $display("FAIL b2b_ale_count got=%0d exp=3", n_ale);
    end else begin
      total++;
      if (ale_idx[1] - ale_idx[0] !== 6) begin
        bad++; $display("FAIL b2b_spacing0 got=%0d exp=6", ale_idx[1] - ale_idx[0]);
      end
      total++;
      if (ale_idx[2] - ale_idx[1] !== 6) begin
        bad++; $display("FAIL b2b_spacing1 got=%0d exp=6", ale_idx[2] - ale_idx[1]);
      end
    end
    total++;
    if (rdy_vec[18:0] !== 19'h41041) begin
      bad++; $display("FAIL b2b_ready_pattern got=%h exp=41041", rdy_vec[18:0]);
    end
  endtask

  task automatic test_idle_gap3();
    int          ale_idx [2];
    int          n_ale   = 0;
    int          accepts = 0;
    int          rsp_idx = -1;
    logic        ale_q   = 1'b0;
    logic [29:0] rdy_vec = '0;
    @(negedge clock);
    req3_valid = 1'b1; req3_write = 1'b0; req3_addr = 20'h00ABC;
    for (int i = 0; i < 24; i++) begin
      if (ale3 && !ale_q && n_ale < 2) begin
        ale_idx[n_ale] = i;
        n_ale++;
      end
      ale_q = ale3;
      rdy_vec[i] = req3_ready;
      if (rsp3_valid && rsp_idx < 0) rsp_idx = i;
      if (req3_valid && req3_ready) accepts++;
      @(negedge clock);
      if (accepts == 2) req3_valid = 1'b0;
    end
    total++;
    if (n_ale !== 2 || ale_idx[1] - ale_idx[0] !== 8) begin
      bad++; $display("FAIL gap3_spacing got=%0d exp=8 (count %0d)", ale_idx[1] - ale_idx[0], n_ale);
    end
    total++;
    if (rsp_idx !== 5) begin
      bad++; $display("FAIL gap3_rsp_index got=%0d exp=5", rsp_idx);
    end
    total++;
    if (rdy_vec[16:0] !== 17'h10101) begin
      bad++; $display("FAIL gap3_ready_pattern got=%h exp=10101", rdy_vec[16:0]);
    end
    total++;
    if ({cs3, rd3, wr3, a3, rsp3_rdata} !== {3'b011, 12'h00A, 8'h96}) begin
      bad++; $display("FAIL gap3_idle_state got=%h exp=%h", {cs3, rd3, wr3, a3, rsp3_rdata},
                      {3'b011, 12'h00A, 8'h96});
    end
  endtask

  task automatic test_reset_mid_write();
    logic stray = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00ABC; req_wdata = 8'h77;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({rd, wr} !== 2'b10) begin
      bad++; $display("FAIL midrst_strobe got=%b exp=10", {rd, wr});
    end
    reset = 1'b1;
    @(negedge clock);
    total++;
    if ({cs, ale, rd, wr, rsp_valid} !== 5'b00110) begin
      bad++; $display("FAIL midrst_ctl got=%b exp=00110", {cs, ale, rd, wr, rsp_valid});
    end
    probe = 1'b1; #1;
    total++;
    if (ad !== 8'h00) begin
      bad++; $display("FAIL midrst_ad_release got=%h exp=00", ad);
    end
    probe = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || cs !== 1'b0) stray = 1'b1;
    end
    total++;
    if (stray !== 1'b0) begin
      bad++; $display("FAIL midrst_quiet got=%b exp=0", stray);
    end
    bus_txn(1'b0, 20'h00ABC, 8'h00, 8'hE6, "after_reset");
  endtask

`ifdef BUS_WAIT_STATE_EN
  task automatic test_wait_state();
    int   rd_low  = 0;
    int   rsp_idx = -1;
    logic wr_low  = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00777;
    ready_in = 1'b0; ovr_en = 1'b1; ovr_val = 8'h11;
    for (int i = 1; i < 10; i++) begin
      @(negedge clock);
      req_valid = 1'b0;
      if (i == 6) begin
        ready_in = 1'b1;
        ovr_val  = 8'h5A;
      end
      if (rd === 1'b0) rd_low++;
      if (wr === 1'b0) wr_low = 1'b1;
      if (rsp_valid && rsp_idx < 0) rsp_idx = i;
    end
    ovr_en = 1'b0;
    total++;
    if (rd_low !== 4) begin
      bad++; $display("FAIL wait_rd_low got=%0d exp=4", rd_low);
    end
    total++;
    if (rsp_idx !== 7) begin
      bad++; $display("FAIL wait_rsp_index got=%0d exp=7", rsp_idx);
    end
    total++;
    if ({wr_low, rsp_rdata} !== {1'b0, 8'h5A}) begin
      bad++; $display("FAIL wait_rdata got=%h exp=05A", {wr_low, rsp_rdata});
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 20'd0; req_wdata = 8'd0;
    req3_valid = 1'b0; req3_write = 1'b0; req3_addr = 20'd0; req3_wdata = 8'd0;
    probe = 1'b0; ovr_en = 1'b0; ovr_val = 8'd0;
`ifdef BUS_WAIT_STATE_EN
    ready_in = 1'b1;
`endif
    test_reset();
    test_read();
    test_write_readback();
    test_back_to_back();
    test_idle_gap3();
    test_reset_mid_write();
`ifdef BUS_WAIT_STATE_EN
    test_wait_state();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
